// File: rtl/obi_regs_arbiter.sv
// Round-robin OBI arbiter feeding the GPU configuration register slave.
// Keeps one downstream transaction in flight and converts a missing response into an error beat.
module obi_regs_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             m_req_i,
    input  logic [NUM_REQ-1:0]             m_we_i,
    input  logic [NUM_REQ-1:0][3:0]        m_be_i,
    input  logic [NUM_REQ-1:0][31:0]       m_addr_i,
    input  logic [NUM_REQ-1:0][31:0]       m_wdata_i,
    output logic [NUM_REQ-1:0]             m_gnt_o,
    output logic [NUM_REQ-1:0]             m_rvalid_o,
    output logic [31:0]                    m_rdata_o,
    output logic                           s_req_o,
    output logic                           s_we_o,
    output logic [3:0]                     s_be_o,
    output logic [31:0]                    s_addr_o,
    output logic [31:0]                    s_wdata_o,
    input  logic                           s_gnt_i,
    input  logic                           s_rvalid_i,
    input  logic [31:0]                    s_rdata_i,
    output logic                           err_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR_RSP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   owner_q;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_inc;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   ptr_next;
    logic [IW:0]     sum;
    logic            found;
    logic            any_req;

    assign any_req  = |m_req_i;
    assign cnt_inc  = cnt_q + 8'd1;
    assign ptr_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
            if (!found && m_req_i[sum[IW-1:0]]) begin
                found  = 1'b1;
                winner = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        err_o      = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        s_req_o          = 1'b1;
                        s_we_o           = m_we_i[winner];
                        s_be_o           = m_be_i[winner];
                        s_addr_o         = m_addr_i[winner];
                        s_wdata_o        = m_wdata_i[winner];
                        m_gnt_o[winner]  = s_gnt_i;
                    end
                end
                BUSY: begin
                    if (s_rvalid_i) begin
                        m_rvalid_o[owner_q] = 1'b1;
                        m_rdata_o           = s_rdata_i;
                    end
                end
                ERR_RSP: begin
                    m_rvalid_o[owner_q] = 1'b1;
                    m_rdata_o           = 32'hDEAD_BEEF;
                    err_o               = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req && s_gnt_i) begin
                        owner_q <= winner;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A response on the limit cycle still wins over the timeout.
                    if (s_rvalid_i) begin
                        rr_ptr_q <= ptr_next;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == TO_LAST) state_q <= ERR_RSP;
                    end
                end
                ERR_RSP: begin
                    rr_ptr_q <= ptr_next;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_regs_arbiter.sv
// Directed per-cycle vector bench for obi_regs_arbiter (NUM_REQ=2, TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 2ns later.
module tb_obi_regs_arbiter;

    localparam logic [31:0] WD1 = 32'h0000_0BB1;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst_ni;
    logic [1:0]        m_req_i;
    logic [1:0]        m_we_i;
    logic [1:0][3:0]   m_be_i;
    logic [1:0][31:0]  m_addr_i;
    logic [1:0][31:0]  m_wdata_i;
    logic [1:0]        m_gnt_o;
    logic [1:0]        m_rvalid_o;
    logic [31:0]       m_rdata_o;
    logic              s_req_o;
    logic              s_we_o;
    logic [3:0]        s_be_o;
    logic [31:0]       s_addr_o;
    logic [31:0]       s_wdata_o;
    logic              s_gnt_i;
    logic              s_rvalid_i;
    logic [31:0]       s_rdata_i;
    logic              err_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] regs [4];

    obi_regs_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave register file: captures granted writes.
    always @(posedge clk) begin
        if (rst_ni && s_req_o && s_gnt_i && s_we_o)
            regs[s_addr_o[3:2]] <= s_wdata_o;
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        sreq;
        logic [31:0] saddr;
        logic [31:0] swd;
        logic        swe;
        logic [3:0]  sbe;
        logic [1:0]  mgnt;
        logic [1:0]  mrv;
        logic [31:0] mrd;
        logic        err;
    } vec_t;

    function automatic vec_t v(
        logic [1:0] req, logic [1:0] we, logic [31:0] a0, logic [31:0] a1,
        logic [31:0] wd0, logic gnt, logic rv, logic [31:0] rd,
        logic sreq, logic [31:0] saddr, logic [31:0] swd, logic swe,
        logic [3:0] sbe, logic [1:0] mgnt, logic [1:0] mrv,
        logic [31:0] mrd, logic err);
        vec_t t;
        t.req = req;   t.we = we;     t.a0 = a0;     t.a1 = a1;
        t.wd0 = wd0;   t.gnt = gnt;   t.rv = rv;     t.rd = rd;
        t.sreq = sreq; t.saddr = saddr; t.swd = swd; t.swe = swe;
        t.sbe = sbe;   t.mgnt = mgnt; t.mrv = mrv;   t.mrd = mrd;
        t.err = err;
        return t;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
                     m_gnt_o, m_rvalid_o, m_rdata_o, err_o});
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] wd0, input logic gnt,
                         input logic rv, input logic [31:0] rd);
        m_req_i    = req;
        m_we_i     = we;
        m_be_i     = {4'h3, 4'hF};
        m_addr_i   = {a1, a0};
        m_wdata_i  = {WD1, wd0};
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rd;
    endtask

    vec_t tbl[$];

    initial begin
        // req we a0 a1 wd0 gnt rv rd | sreq saddr swd swe sbe mgnt mrv mrd err
        tbl.push_back(v(2'b01,2'b01,0,0,1, 1,0,0,   1,0,1,1,4'hF,     2'b01,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,0,0,0, 1,1,0,   0,0,0,0,4'h0,     2'b00,2'b01,0,0));
        tbl.push_back(v(2'b10,2'b00,0,0,0, 1,0,0,   1,0,WD1,0,4'h3,   2'b10,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,0,0,0, 1,1,1,   0,0,0,0,4'h0,     2'b00,2'b10,1,0));
        tbl.push_back(v(2'b00,2'b00,0,0,0, 0,1,'h55,0,0,0,0,4'h0,     2'b00,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   1,'h10,0,0,4'hF,   2'b01,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,1,'hA, 0,0,0,0,4'h0,      2'b00,2'b01,'hA,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   1,'h20,WD1,0,4'h3, 2'b10,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,1,'hB, 0,0,0,0,4'h0,      2'b00,2'b10,'hB,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   1,'h10,0,0,4'hF,   2'b01,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,1,'hC, 0,0,0,0,4'h0,      2'b00,2'b01,'hC,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   1,'h20,WD1,0,4'h3, 2'b10,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,1,'hD, 0,0,0,0,4'h0,      2'b00,2'b10,'hD,0));
        tbl.push_back(v(2'b10,2'b00,'h10,'h20,0, 1,0,0,   1,'h20,WD1,0,4'h3, 2'b10,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,1,'hE, 0,0,0,0,4'h0,      2'b00,2'b10,'hE,0));
        tbl.push_back(v(2'b11,2'b00,'h10,'h20,0, 1,0,0,   1,'h10,0,0,4'hF,   2'b01,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,1,'hF, 0,0,0,0,4'h0,      2'b00,2'b01,'hF,0));
        tbl.push_back(v(2'b01,2'b00,'h10,'h20,0, 0,0,0,   1,'h10,0,0,4'hF,   2'b00,2'b00,0,0));
        tbl.push_back(v(2'b01,2'b00,'h10,'h20,0, 1,0,0,   1,'h10,0,0,4'hF,   2'b01,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,1,'h77,0,0,0,0,4'h0,      2'b00,2'b01,'h77,0));
        tbl.push_back(v(2'b10,2'b00,'h10,'h20,0, 1,0,0,   1,'h20,WD1,0,4'h3, 2'b10,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,1,'h1234,0,0,0,0,4'h0,    2'b00,2'b10,DB,1));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,1,'h99,0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b01,2'b00,'h10,'h20,0, 1,0,0,   1,'h10,0,0,4'hF,   2'b01,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,1,'h42,0,0,0,0,4'h0,      2'b00,2'b01,'h42,0));
        tbl.push_back(v(2'b00,2'b00,'h10,'h20,0, 1,0,0,   0,0,0,0,4'h0,      2'b00,2'b00,0,0));

        foreach (regs[i]) regs[i] = '0;

        // Reset with every input active: all outputs must stay low.
        rst_ni = 1'b0;
        drive(2'b11, 2'b11, 'h10, 'h20, 'h5, 1'b1, 1'b1, 'h33);
        #2;
        chk("reset_outputs", outs(), 128'd0);
        drive(2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1,
                  tbl[i].wd0, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            #2;
            chk($sformatf("vec%0d", i), outs(),
                128'({tbl[i].sreq, tbl[i].swe, tbl[i].sbe, tbl[i].saddr,
                      tbl[i].swd, tbl[i].mgnt, tbl[i].mrv, tbl[i].mrd,
                      tbl[i].err}));
        end

        chk("slave_regs0", 128'(regs[0]), 128'd1);

        // Reset during BUSY: pointer is 1, so requester 1 wins first.
        @(negedge clk);
        drive(2'b11, 2'b00, 'h10, 'h20, 0, 1'b1, 1'b0, 0);
        #2;
        chk("abort_grant", 128'(m_gnt_o), 128'(2'b10));
        @(negedge clk);
        drive(2'b00, 2'b00, 'h10, 'h20, 0, 1'b1, 1'b0, 0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("abort_in_reset", outs(), 128'd0);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        drive(2'b00, 2'b00, 'h10, 'h20, 0, 1'b1, 1'b1, 'h66);
        #2;
        chk("abort_no_rsp", 128'({m_rvalid_o, err_o, m_rdata_o}), 128'd0);
        @(negedge clk);
        drive(2'b11, 2'b00, 'h10, 'h20, 0, 1'b1, 1'b0, 0);
        #2;
        chk("abort_ptr_reset", 128'(m_gnt_o), 128'(2'b01));
        @(negedge clk);
        drive(2'b00, 2'b00, 'h10, 'h20, 0, 1'b1, 1'b1, 'h5);
        #2;
        chk("abort_resume", 128'({m_rvalid_o, m_rdata_o}),
            128'({2'b01, 32'h5}));

        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
